matrix_loader: RTL
==================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter W, default 8: element width in bits (signed two's complement, passed through unmodified).
REQ-002 Parameter MAX_N, default 5: matrix frame dimension; A_flat width = MAX_N*MAX_N*W (200 at defaults).
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin loading a new matrix.
REQ-006 size  input  3  matrix order N for the load; legal values 2..MAX_N; sampled with start.
REQ-007 in_valid  input  1  element beat valid.
REQ-008 in_data  input  W  element value, row-major order.
REQ-009 in_ready  output  1  loader accepts a beat this cycle.
REQ-010 A_flat  output  MAX_N*MAX_N*W  packed matrix frame; element (r,c) at bits [(r*MAX_N+c)*W +: W].
REQ-011 mat_valid  output  1  A_flat holds a complete matrix.
REQ-012 mat_ack  input  1  downstream (determinant stage) has consumed A_flat.
REQ-013 n_out  output  3  latched matrix order of the current/held matrix.
REQ-014 busy  output  1  high in LOAD or HOLD.
REQ-015 size_err  output  1  one-cycle pulse when start arrives with illegal size.

Function
REQ-016 FSM states: IDLE, LOAD, HOLD; registered outputs only, no combinational path from in_valid to in_ready.
REQ-017 IDLE: in_ready=0, mat_valid=0; start with size in 2..MAX_N -> clear A_flat to all zeros, latch n_out=size, row=0, col=0, go LOAD next edge.
REQ-018 IDLE: start with size <2 or >MAX_N -> size_err=1 for exactly one cycle, stay IDLE, A_flat and n_out unchanged.
REQ-019 LOAD: in_ready=1; beat transfers when in_valid&in_ready on a rising edge; in_data written to element (row,col).
REQ-020 Index advance per transfer: if col==n_out-1 then col=0, row=row+1, else col=col+1; positions with row or col >= n_out remain zero.
REQ-021 Transfer of element (n_out-1,n_out-1) -> HOLD next edge; in_ready=0 and mat_valid=1 in the cycle after the final transfer (latency 1 cycle).
REQ-022 Exactly n_out*n_out transfers complete a load; in_valid with in_ready=0 is ignored and consumes no element.
REQ-023 In_valid gaps in LOAD are legal; indices hold, FSM stays in LOAD indefinitely.
REQ-024 HOLD: A_flat, n_out stable; mat_valid=1 until mat_ack sampled high, then IDLE and mat_valid=0 next edge; A_flat retained (not cleared) in IDLE.
REQ-025 mat_ack outside HOLD has no effect.
REQ-026 start in LOAD or HOLD is ignored (no restart, no size_err).
REQ-027 start coincident with mat_ack in HOLD: return to IDLE only; start is dropped.
REQ-028 busy = (state != IDLE).
REQ-029 Element values unmodified; no arithmetic, sign extension, or saturation.

Reset
REQ-030 reset asserted (any state, including mid-LOAD) immediately forces IDLE, A_flat=0, n_out=0, row=col=0, in_ready=0, mat_valid=0, busy=0, size_err=0.
REQ-031 After reset deassertion, the first cycle accepts start normally; partial loads are discarded, never completed.

Verification
REQ-032 start,size=4; stream 1..16 back-to-back -> mat_valid=1 one cycle after 16th transfer; A_flat[7:0]=1, [31:24]=4, [47:40]=5, [151:144]=16, byte 4 and bytes 20..24 = 0.
REQ-033 start,size=2; beats 0x80,0x7F,0xFF,0x01 with in_valid gaps of 3 cycles -> bytes 0,1,5,6 = 0x80,0x7F,0xFF,0x01; all other bytes 0; n_out=2.
REQ-034 start,size=6 and start,size=1 -> size_err pulses one cycle each; state stays IDLE, in_ready=0, A_flat unchanged.
REQ-035 Complete 5x5 load, hold mat_ack=0 for 10 cycles with in_valid=1 and start=1 -> A_flat stable, in_ready=0, no restart; mat_ack=1 -> mat_valid=0 next cycle.
REQ-036 size=3 load, reset asserted after 5 transfers -> all outputs zero same cycle; new size=3 load of 9 beats produces correct frame with no residue from aborted load.
REQ-037 Back-to-back: mat_ack then start next cycle with size=3 -> previous frame cleared to zero before first new beat lands.

Source files
------------

// File: rtl/matrix_loader.sv
// Collects an N x N matrix (N = 2..MAX_N) from a row-major element stream into a
// zero-padded MAX_N x MAX_N frame and holds it until the downstream stage acknowledges.
//
// state | meaning
// IDLE  | waiting for start; last frame retained; in_ready=0, mat_valid=0
// LOAD  | accepting beats into (row,col); in_ready=1
// HOLD  | frame complete; mat_valid=1 until mat_ack
module matrix_loader #(
  parameter int W     = 8,
  parameter int MAX_N = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               size,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic [MAX_N*MAX_N*W-1:0] A_flat,
  output logic                     mat_valid,
  input  logic                     mat_ack,
  output logic [2:0]               n_out,
  output logic                     busy,
  output logic                     size_err
);

  localparam int NE = MAX_N * MAX_N;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t     state, state_nx;
  logic [2:0] row, col;
  logic       size_ok, last_col, last_beat;

  assign size_ok   = (int'(size) >= 2) && (int'(size) <= MAX_N);
  assign last_col  = (col == n_out - 3'd1);
  assign last_beat = last_col && (row == n_out - 3'd1);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    mat_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start && size_ok) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_beat) state_nx = HOLD;
      end
      HOLD: begin
        mat_valid = 1'b1;
        busy      = 1'b1;
        if (mat_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      A_flat   <= '0;
      n_out    <= 3'd0;
      row      <= 3'd0;
      col      <= 3'd0;
      size_err <= 1'b0;
    end else begin
      state    <= state_nx;
      size_err <= (state == IDLE) && start && !size_ok;
      case (state)
        IDLE: begin
          if (start && size_ok) begin
            A_flat <= '0;
            n_out  <= size;
            row    <= 3'd0;
            col    <= 3'd0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            // in_ready is 1 throughout LOAD, so every valid beat is a transfer
            for (int e = 0; e < NE; e++) begin
              if (e == int'(row) * MAX_N + int'(col)) A_flat[e*W +: W] <= in_data;
            end
            if (last_col) begin
              col <= 3'd0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
